// File: rtl/gate_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_bist_pkg
// Description : Shared FSM state encodings and 2-input gate truth tables for
//               the gate BIST controller and its test benches.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Truth tables are indexed by {a,b}: bit 0 is a=0,b=0, bit 3 is a=1,b=1.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage
`default_nettype wire

// File: rtl/bist_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : bist_settle_timer
// Description : Down-counter that holds each stimulus vector for SETTLE
//               cycles; flags zero on the cycle y_in is to be sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam logic [3:0] C_RELOAD = 4'(SETTLE - 1);

  logic [3:0] r_count;

  // Load has priority; otherwise count down while enabled, stopping at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (load) begin
      r_count <= C_RELOAD;
    end else if (en && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign zero = (r_count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/gate_bist.sv
`default_nettype none
// ============================================================================
// Module      : gate_bist
// Description : Exhaustive 2-input gate tester. Applies vectors 00,01,10,11,
//               captures the response signature and grades it against a
//               truth table latched at start.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] signature,
  output logic [2:0] err_count
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_idx;
  logic [3:0] r_expected;
  logic       w_load;
  logic       w_zero;
  logic       w_accept;
  logic       w_sample;
  logic       w_mismatch;
  logic [2:0] w_err_nxt;

  bist_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .en    (r_state == APPLY),
    .zero  (w_zero)
  );

  assign w_accept   = (r_state == IDLE) && start;
  assign w_sample   = (r_state == APPLY) && w_zero;
  assign w_mismatch = (y_in != r_expected[r_idx]);
  assign w_err_nxt  = err_count + 3'(w_mismatch);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode, timer reload and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = APPLY;
        end
      end
      APPLY: begin
        busy = 1'b1;
        if (w_zero) begin
          if (r_idx != 2'd3) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Vector index, stimulus outputs and result capture; the final vector's
  // grade is folded into pass on the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= 2'd0;
      r_expected <= 4'd0;
      signature  <= 4'd0;
      err_count  <= 3'd0;
      pass       <= 1'b0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
    end else if (w_accept) begin
      r_idx      <= 2'd0;
      r_expected <= expected;
      signature  <= 4'd0;
      err_count  <= 3'd0;
      pass       <= 1'b0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
    end else if (w_sample) begin
      signature[r_idx] <= y_in;
      err_count        <= w_err_nxt;
      if (r_idx != 2'd3) begin
        r_idx          <= r_idx + 2'd1;
        {a_out, b_out} <= r_idx + 2'd1;
      end else begin
        {a_out, b_out} <= 2'b00;
        pass           <= (w_err_nxt == 3'd0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_bist
// Description : Directed self-checking bench for gate_bist; the gate under
//               test is modelled by a truth table driven from a_out/b_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_bist;
  import gate_bist_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start3;
  logic [3:0] expected;
  logic [3:0] gate1, gate3;

  logic       y1, a1, b1, busy1, done1, pass1;
  logic [3:0] sig1;
  logic [2:0] err1;
  logic       y3, a3, b3, busy3, done3, pass3;
  logic [3:0] sig3;
  logic [2:0] err3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Gates under test, described by their truth tables.
  assign y1 = gate1[{a1, b1}];
  assign y3 = gate3[{a3, b3}];

  gate_bist #(.SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .expected(expected), .y_in(y1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1), .err_count(err1)
  );

  gate_bist #(.SETTLE(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .expected(expected), .y_in(y3),
    .a_out(a3), .b_out(b3), .busy(busy3), .done(done3), .pass(pass3),
    .signature(sig3), .err_count(err3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full SETTLE=1 pass on dut1 with cycle-by-cycle checks.
  task automatic run1(input string tag, input logic [3:0] exp_sig,
                      input logic [2:0] exp_err, input logic exp_pass);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check({tag, "_ab"},   {6'd0, a1, b1}, 8'(c - 1));
      check({tag, "_busy"}, {7'd0, busy1}, 8'd1);
      check({tag, "_done"}, {7'd0, done1}, 8'd0);
      step();
    end
    check({tag, "_done5"}, {7'd0, done1}, 8'd1);
    check({tag, "_sig"},   {4'd0, sig1}, {4'd0, exp_sig});
    check({tag, "_err"},   {5'd0, err1}, {5'd0, exp_err});
    check({tag, "_pass"},  {7'd0, pass1}, {7'd0, exp_pass});
    step();
    check({tag, "_idle"},  {6'd0, busy1, done1}, 8'd0);
    check({tag, "_hold"},  {sig1, err1, pass1}, {exp_sig, exp_err, exp_pass});
  endtask

  initial begin
    reset    = 1'b1;
    start1   = 1'b0;
    start3   = 1'b0;
    expected = TT_NAND;
    gate1    = TT_NAND;
    gate3    = TT_NAND;
    step();
    step();
    check("rst_state", {a1, b1, busy1, done1, pass1, err1}, 8'd0);
    check("rst_sig",   {4'd0, sig1}, 8'd0);

    // Reset must win over a simultaneous start.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    reset  = 1'b0;
    check("rst_prio", {7'd0, busy1}, 8'd0);
    step();
    check("rst_prio2", {7'd0, busy1}, 8'd0);

    // Correct NAND, stuck-at-0 output, AND substituted for NAND.
    gate1 = TT_NAND;
    run1("nand", 4'b0111, 3'd0, 1'b1);
    gate1 = 4'b0000;
    run1("stuck0", 4'b0000, 3'd3, 1'b0);
    gate1 = TT_AND;
    run1("and", 4'b1000, 3'd4, 1'b0);

    // SETTLE=3: each vector held three cycles, done on cycle 13.
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check("s3_ab",   {6'd0, a3, b3}, 8'((c - 1) / 3));
      check("s3_busy", {6'd0, busy3, done3}, 8'd2);
      step();
    end
    check("s3_done", {6'd0, busy3, done3}, 8'd1);
    check("s3_res",  {sig3, err3, pass3}, {4'b0111, 3'd0, 1'b1});

    // Restart attempts and an expected change during a pass are ignored.
    gate1 = TT_NAND;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      start1 = (c == 2 || c == 5);
      if (c == 3) expected = TT_OR;
      check("ign_busy", {7'd0, busy1}, {7'd0, c <= 4});
      check("ign_done", {7'd0, done1}, {7'd0, c == 5});
      step();
    end
    start1   = 1'b0;
    expected = TT_NAND;
    check("ign_norestart", {6'd0, busy1, done1}, 8'd0);
    check("ign_res", {sig1, err1, pass1}, {4'b0111, 3'd0, 1'b1});

    // Reset mid-pass aborts with no done pulse; a later start runs cleanly.
    gate1  = TT_AND;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_state", {a1, b1, busy1, done1, pass1, err1}, 8'd0);
    for (int c = 0; c < 4; c++) begin
      check("abort_nodone", {6'd0, busy1, done1}, 8'd0);
      step();
    end
    gate1 = TT_NAND;
    run1("after_rst", 4'b0111, 3'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
